// File: rtl/morse_pkg.sv
// Shared types and defaults for the Morse key decoder and the downstream
// character lookup ROM (which consumes the symbol length/pattern widths).
package morse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   // Default timing, in half-second ticks
   localparam int DASH_TICKS_DEF       = 2;
   localparam int LETTER_GAP_TICKS_DEF = 3;
   localparam int WORD_GAP_TICKS_DEF   = 7;
   localparam int MAX_ELEMS_DEF        = 5;

   // Symbol interface widths shared with the character lookup ROM
   localparam int SYM_LEN_W  = 3;
   localparam int SYM_BITS_W = MAX_ELEMS_DEF;

   // Press/gap tick counters
   localparam int TICK_W = 4;

   // Saturating increment: counters stick at all-ones instead of wrapping
   function automatic logic [TICK_W-1:0] sat_inc(input logic [TICK_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer plus edge register for a raw front-panel input.
// No debounce: every synchronized transition yields a one-cycle pulse.
module key_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic sync1_q, sync2_q, prev_q;

   // Synchronize the asynchronous key and keep one cycle of history
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign level_o = sync2_q;
   assign rise_o  = sync2_q & ~prev_q;
   assign fall_o  = ~sync2_q & prev_q;

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key decoder: times presses/releases in half-second ticks, builds
// a dot/dash pattern per letter and emits letter and word-space events.
module morse_key_decoder
   import morse_pkg::*;
#(
   parameter int DASH_TICKS       = DASH_TICKS_DEF,
   parameter int LETTER_GAP_TICKS = LETTER_GAP_TICKS_DEF,
   parameter int WORD_GAP_TICKS   = WORD_GAP_TICKS_DEF,
   parameter int MAX_ELEMS        = MAX_ELEMS_DEF
) (
   input  logic                 iCLK,
   input  logic                 iRST_n,
   input  logic [3:0]           iHalfSec,
   input  logic                 iKey,
   output logic                 oSymValid,
   output logic [SYM_LEN_W-1:0] oSymLen,
   output logic [MAX_ELEMS-1:0] oSymBits,
   output logic                 oSymErr,
   output logic                 oSpace,
   output logic                 oKeyDown
);

   localparam logic [TICK_W-1:0]    DASH_T   = TICK_W'(DASH_TICKS);
   localparam logic [TICK_W-1:0]    LETTER_T = TICK_W'(LETTER_GAP_TICKS);
   localparam logic [TICK_W-1:0]    WORD_T   = TICK_W'(WORD_GAP_TICKS);
   localparam logic [SYM_LEN_W-1:0] MAX_E    = SYM_LEN_W'(MAX_ELEMS);

   logic key_rise, key_fall;

   key_sync u_key_sync (
      .clk_i   (iCLK),
      .rst_ni  (iRST_n),
      .key_i   (iKey),
      .level_o (oKeyDown),
      .rise_o  (key_rise),
      .fall_o  (key_fall)
   );

   state_e                 state_q, state_d;
   logic [3:0]             hs_prev_q;
   logic [TICK_W-1:0]      press_q, press_d;
   logic [TICK_W-1:0]      gap_q, gap_d;
   logic [SYM_LEN_W-1:0]   cnt_q, cnt_d;
   logic [MAX_ELEMS-1:0]   pat_q, pat_d;
   logic                   err_q, err_d;
   logic                   sym_valid_q, sym_valid_d;
   logic [SYM_LEN_W-1:0]   sym_len_q, sym_len_d;
   logic [MAX_ELEMS-1:0]   sym_bits_q, sym_bits_d;
   logic                   sym_err_q, sym_err_d;
   logic                   space_q, space_d;

   logic                   tick;
   logic [TICK_W-1:0]      press_eff;
   logic [TICK_W-1:0]      gap_inc;

   // Any change of the half-second counter (including 15->0 or a jump) is one tick
   assign tick      = (iHalfSec != hs_prev_q);
   // Press length as of this cycle, counting a tick that lands with the release
   assign press_eff = tick ? sat_inc(press_q) : press_q;
   assign gap_inc   = sat_inc(gap_q);

   // Next-state logic: element timing, letter assembly, gap events
   always_comb begin
      state_d     = state_q;
      press_d     = press_q;
      gap_d       = gap_q;
      cnt_d       = cnt_q;
      pat_d       = pat_q;
      err_d       = err_q;
      sym_valid_d = 1'b0;
      space_d     = 1'b0;
      sym_len_d   = sym_len_q;
      sym_bits_d  = sym_bits_q;
      sym_err_d   = sym_err_q;

      case (state_q)
         ST_IDLE: begin
            if (key_rise) begin
               state_d = ST_PRESS;
               press_d = '0;
               cnt_d   = '0;
               pat_d   = '0;
               err_d   = 1'b0;
            end
         end

         ST_PRESS: begin
            press_d = press_eff;
            if (key_fall) begin
               state_d = ST_GAP;
               gap_d   = '0;
               if (cnt_q < MAX_E) begin
                  pat_d[cnt_q] = (press_eff >= DASH_T);
                  cnt_d        = cnt_q + 1'b1;
               end else begin
                  // Overlong letter: keep the first MAX_ELEMS, flag it
                  err_d = 1'b1;
               end
            end
         end

         ST_GAP: begin
            if (key_rise) begin
               // New element of the same letter; a coincident tick is dropped
               state_d = ST_PRESS;
               press_d = '0;
            end else if (tick) begin
               gap_d = gap_inc;
               if (gap_inc == LETTER_T && cnt_q != '0) begin
                  sym_valid_d = 1'b1;
                  sym_len_d   = cnt_q;
                  sym_bits_d  = pat_q;
                  sym_err_d   = err_q;
                  cnt_d       = '0;
                  pat_d       = '0;
                  err_d       = 1'b0;
               end
               if (gap_inc == WORD_T) begin
                  space_d = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State, counters and registered event outputs
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q     <= ST_IDLE;
         hs_prev_q   <= '0;
         press_q     <= '0;
         gap_q       <= '0;
         cnt_q       <= '0;
         pat_q       <= '0;
         err_q       <= 1'b0;
         sym_valid_q <= 1'b0;
         sym_len_q   <= '0;
         sym_bits_q  <= '0;
         sym_err_q   <= 1'b0;
         space_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         hs_prev_q   <= iHalfSec;
         press_q     <= press_d;
         gap_q       <= gap_d;
         cnt_q       <= cnt_d;
         pat_q       <= pat_d;
         err_q       <= err_d;
         sym_valid_q <= sym_valid_d;
         sym_len_q   <= sym_len_d;
         sym_bits_q  <= sym_bits_d;
         sym_err_q   <= sym_err_d;
         space_q     <= space_d;
      end
   end

   assign oSymValid = sym_valid_q;
   assign oSymLen   = sym_len_q;
   assign oSymBits  = sym_bits_q;
   assign oSymErr   = sym_err_q;
   assign oSpace    = space_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: letter table, timing corner cases and a
// randomized element stream checked against a tick-level letter model.
module tb_morse_key_decoder;

   logic       iCLK = 1'b0;
   logic       iRST_n = 1'b0;
   logic [3:0] iHalfSec = 4'd0;
   logic       iKey = 1'b0;
   logic       oSymValid;
   logic [2:0] oSymLen;
   logic [4:0] oSymBits;
   logic       oSymErr;
   logic       oSpace;
   logic       oKeyDown;

   morse_key_decoder dut (
      .iCLK      (iCLK),
      .iRST_n    (iRST_n),
      .iHalfSec  (iHalfSec),
      .iKey      (iKey),
      .oSymValid (oSymValid),
      .oSymLen   (oSymLen),
      .oSymBits  (oSymBits),
      .oSymErr   (oSymErr),
      .oSpace    (oSpace),
      .oKeyDown  (oKeyDown)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      bit sp;
      int len;
      int bits;
      int err;
   } ev_t;

   typedef struct {
      int n;
      int p[6];
      int len;
      int bits;
      int err;
   } vec_t;

   int  tests = 0;
   int  fails = 0;
   int  both_cnt = 0;
   ev_t evq[$];
   ev_t mon_e;

   // Event monitor: records every letter / space pulse
   always @(negedge iCLK) begin
      if (iRST_n) begin
         if (oSymValid && oSpace) both_cnt++;
         if (oSymValid) begin
            mon_e.sp = 1'b0; mon_e.len = int'(oSymLen);
            mon_e.bits = int'(oSymBits); mon_e.err = int'(oSymErr);
            evq.push_back(mon_e);
         end
         if (oSpace) begin
            mon_e.sp = 1'b1; mon_e.len = 0; mon_e.bits = 0; mon_e.err = 0;
            evq.push_back(mon_e);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge iCLK) iHalfSec = iHalfSec + 4'd1;
      repeat (3) @(negedge iCLK);
   endtask

   task automatic key(input bit v);
      @(negedge iCLK) iKey = v;
      repeat (4) @(negedge iCLK);
   endtask

   task automatic elem(input int p, input int g);
      key(1'b1);
      repeat (p) tick();
      key(1'b0);
      repeat (g) tick();
   endtask

   task automatic chk_ev(input string nm, input int idx, input ev_t e);
      if (evq.size() > idx) begin
         chk({nm, "_sp"},   int'(evq[idx].sp), int'(e.sp));
         chk({nm, "_len"},  evq[idx].len,  e.len);
         chk({nm, "_bits"}, evq[idx].bits, e.bits);
         chk({nm, "_err"},  evq[idx].err,  e.err);
      end
   endtask

   vec_t tbl[6];
   ev_t  expq[$];
   ev_t  e;
   int   rp[40];
   int   rg[40];
   int   gaps[6] = '{1, 1, 2, 3, 4, 8};

   initial begin
      tbl[0] = '{1, '{1, 0, 0, 0, 0, 0}, 1, 0, 0};   // E
      tbl[1] = '{4, '{3, 1, 3, 1, 0, 0}, 4, 5, 0};   // C
      tbl[2] = '{6, '{1, 1, 1, 1, 1, 1}, 5, 0, 1};   // overlong
      tbl[3] = '{2, '{1, 2, 0, 0, 0, 0}, 2, 2, 0};   // A, error cleared
      tbl[4] = '{4, '{2, 2, 1, 2, 0, 0}, 4, 11, 0};  // Q
      tbl[5] = '{5, '{2, 3, 2, 2, 4, 0}, 5, 31, 0};  // 0

      // Reset state
      repeat (3) @(negedge iCLK);
      chk("reset_outs", int'({oSymValid, oSymLen, oSymBits, oSymErr, oSpace, oKeyDown}), 0);
      iRST_n = 1'b1;
      repeat (3) @(negedge iCLK);

      // Letter table, each followed by a word gap
      for (int i = 0; i < 6; i++) begin
         evq.delete();
         for (int j = 0; j < tbl[i].n; j++)
            elem(tbl[i].p[j], (j == tbl[i].n - 1) ? 3 : 1);
         chk($sformatf("tbl%0d_nev", i), evq.size(), 1);
         e.sp = 1'b0; e.len = tbl[i].len; e.bits = tbl[i].bits; e.err = tbl[i].err;
         chk_ev($sformatf("tbl%0d", i), 0, e);
         repeat (4) tick();
         chk($sformatf("tbl%0d_nev2", i), evq.size(), 2);
         if (evq.size() > 1) chk($sformatf("tbl%0d_space", i), int'(evq[1].sp), 1);
      end

      // Word gap with exact one-cycle latency, then silence
      evq.delete();
      elem(1, 0);
      for (int k = 1; k <= 7; k++) begin
         @(negedge iCLK) iHalfSec = iHalfSec + 4'd1;
         @(negedge iCLK);
         chk($sformatf("wg_sv_t%0d", k), int'(oSymValid), int'(k == 3));
         chk($sformatf("wg_sp_t%0d", k), int'(oSpace), int'(k == 7));
         @(negedge iCLK);
         chk($sformatf("wg_hold_t%0d", k), int'({oSymValid, oSpace}), 0);
         @(negedge iCLK);
      end
      chk("wg_len", int'(oSymLen), 1);
      evq.delete();
      repeat (20) tick();
      chk("wg_quiet", evq.size(), 0);

      // Release coincident with the 15->0 wrap tick: press counts 2 -> dash
      evq.delete();
      @(negedge iCLK) iHalfSec = 4'd14;
      repeat (3) @(negedge iCLK);
      key(1'b1);
      tick();
      @(negedge iCLK) iKey = 1'b0;
      @(posedge iCLK);
      @(posedge iCLK);
      @(negedge iCLK) iHalfSec = 4'd0;
      repeat (3) @(negedge iCLK);
      repeat (3) tick();
      e.sp = 1'b0; e.len = 1; e.bits = 1; e.err = 0;
      chk("wrap_nev", evq.size(), 1);
      chk_ev("wrap", 0, e);
      repeat (4) tick();

      // Async reset mid-press after two elements
      elem(1, 1);
      elem(3, 1);
      key(1'b1);
      tick();
      chk("pre_rst_keydown", int'(oKeyDown), 1);
      @(negedge iCLK);
      #1 iRST_n = 1'b0;
      #1 chk("rst_async", int'({oSymValid, oSymLen, oSymBits, oSymErr, oSpace, oKeyDown}), 0);
      iKey = 1'b0;
      repeat (3) @(negedge iCLK);
      iRST_n = 1'b1;
      evq.delete();
      repeat (10) tick();
      chk("post_rst_quiet", evq.size(), 0);

      // Randomized element stream against the letter model
      for (int i = 0; i < 40; i++) begin
         rp[i] = $urandom_range(0, 3);
         rg[i] = gaps[$urandom_range(0, 5)];
      end
      rg[39] = 8;
      begin
         int mlen, mbits, merr;
         mlen = 0; mbits = 0; merr = 0;
         expq.delete();
         for (int i = 0; i < 40; i++) begin
            if (mlen < 5) begin
               if (rp[i] >= 2) mbits = mbits | (1 << mlen);
               mlen++;
            end else merr = 1;
            if (rg[i] >= 3) begin
               e.sp = 1'b0; e.len = mlen; e.bits = mbits; e.err = merr;
               expq.push_back(e);
               mlen = 0; mbits = 0; merr = 0;
            end
            if (rg[i] >= 7) begin
               e.sp = 1'b1; e.len = 0; e.bits = 0; e.err = 0;
               expq.push_back(e);
            end
         end
      end
      evq.delete();
      for (int i = 0; i < 40; i++) elem(rp[i], rg[i]);
      chk("rand_nev", evq.size(), expq.size());
      for (int i = 0; i < expq.size(); i++)
         chk_ev($sformatf("rand%0d", i), i, expq[i]);

      chk("never_both", both_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
- Consumes the free-running 4-bit half-second counter from the clock divider and a raw Morse key input.
- Times key presses and releases in half-second ticks and classifies each element as a dot or a dash.
- Assembles elements into a letter code and detects letter and word gaps.
- Emits registered one-cycle events to the downstream character lookup / LCD writer.

Parameters:
- DASH_TICKS, 2: press of at least this many ticks is a dash; fewer is a dot.
- LETTER_GAP_TICKS, 3: release ticks that close the current letter.
- WORD_GAP_TICKS, 7: release ticks that emit a word space (must exceed LETTER_GAP_TICKS).
- MAX_ELEMS, 5: maximum elements per letter.

Ports:
- iCLK  in  1  system clock (50 MHz).
- iRST_n  in  1  asynchronous active-low reset.
- iHalfSec  in  4  half-second counter from the clock divider; increments once per 0.5 s and wraps 15->0.
- iKey  in  1  raw Morse key, active-high, asynchronous to iCLK.
- oSymValid  out  1  one-cycle pulse: letter complete.
- oSymLen  out  3  element count of the letter, 1..MAX_ELEMS; valid with oSymValid.
- oSymBits  out  MAX_ELEMS  element pattern: bit0 = first element, 1 = dash; unused bits are 0.
- oSymErr  out  1  set with oSymValid when more than MAX_ELEMS elements were keyed.
- oSpace  out  1  one-cycle pulse: word gap detected.
- oKeyDown  out  1  synchronized key level, for the LCD cursor/LED.

Behaviour:
- Reset (iRST_n=0, async): state IDLE, all counters 0, the previous-iHalfSec register 0, and all outputs 0. Synchronizer flops are also 0.
- Key path: 2-flop synchronizer, then an edge register. oKeyDown equals the second sync flop. A rise or fall is detected 2-3 cycles after iKey changes. No debounce is performed; bounces shorter than a tick produce extra dots, and this is documented.
- Tick: a one-cycle internal pulse when iHalfSec differs from its registered previous value. A wrap from 15 to 0 is a tick. Multi-step jumps count as one tick.
- Press counter and gap counter: 4-bit, saturate at 15 and never wrap.
- FSM states: IDLE, PRESS, GAP.
- IDLE:
  - Key rise -> PRESS, press counter = 0, element count = 0, pattern = 0, error = 0.
  - Ticks are ignored.
- PRESS:
  - Each tick increments the press counter.
  - Key fall -> commit the element and go to GAP with gap counter = 0.
  - Commit rule: dash if press counter (including a tick arriving in the fall cycle) >= DASH_TICKS, else dot.
  - If element count < MAX_ELEMS, write the element into pattern[count] and increment count.
  - Otherwise set the error flag and leave count and pattern unchanged.
- GAP:
  - Each tick increments the gap counter.
  - Key rise -> PRESS, press counter = 0, gap counter unchanged. A tick in the same cycle as the rise is dropped.
  - Gap counter reaching LETTER_GAP_TICKS with count > 0: pulse oSymValid for one cycle with oSymLen = count, oSymBits = pattern, oSymErr = error. Then clear count, pattern, and error, and remain in GAP.
  - Gap counter reaching WORD_GAP_TICKS: pulse oSpace for one cycle, then -> IDLE.
- oSymValid and oSpace are never asserted in the same cycle.
- oSymLen, oSymBits, and oSymErr hold their value between pulses.
- Latency: from the tick that completes the gap to oSymValid/oSpace is 1 cycle (registered outputs).
- A press is never lost: a press starting in any state is tracked from the following cycle.
- Async reset mid-letter discards the partial letter; no pulse is emitted.

Decomposition:
- morse_pkg holds:
  - the state enum (IDLE, PRESS, GAP);
  - default values for DASH_TICKS, LETTER_GAP_TICKS, WORD_GAP_TICKS, MAX_ELEMS;
  - the symbol width localparams, shared with the downstream character lookup ROM.
- Sub-module key_sync: 2-flop synchronizer plus rise/fall pulse generator, reset by iRST_n. It is reused for the other front-panel buttons.

Test Plan:
- Press iKey for 1 tick, release for 3 ticks -> oSymValid pulse with oSymLen=1, oSymBits=00000, oSymErr=0 ("E").
- Presses of 3, 1, 3, 1 ticks separated by 1-tick gaps, then a 3-tick gap -> oSymLen=4, oSymBits=00101 ("C" = dash-dot-dash-dot).
- Single dot, then hold released for 7 ticks -> oSymValid at gap tick 3, oSpace at gap tick 7, state returns to IDLE, and no further pulses occur through 20 more ticks.
- Six dots with 1-tick gaps, then a 3-tick gap -> oSymLen=5, oSymBits=00000, oSymErr=1. The next letter reports oSymErr=0.
- Release coincides with the tick where iHalfSec goes 15->0 after one earlier tick -> press counted as 2 ticks, element is a dash.
- Assert iRST_n low mid-press after 2 elements -> all outputs 0 immediately, and no oSymValid after reset release even with the key idle for 10 ticks.
